// File: rtl/ysyx_23060337_fetch_unit_if.sv
// Bus bundle for the fetch unit: redirect input, instruction-memory request/response port,
// and the instruction stream toward the decoder.
interface ysyx_23060337_fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, inst_ready,
        output req_valid, req_addr, inst_valid, inst, inst_pc, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, inst_ready,
        input  req_valid, req_addr, inst_valid, inst, inst_pc, fetch_pc
    );
endinterface

// File: rtl/ysyx_23060337_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory request in flight and
// buffers returned instructions with their PCs in a small FIFO; redirect flushes everything.
module ysyx_23060337_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_23060337_fetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW:0]     count_q;

    logic req_valid;
    logic issue;
    logic push;
    logic pop;
    logic inst_valid;

    always_comb begin
        req_valid  = rst && (state_q == StIdle) && (count_q < DEPTH_CNT) && !bus.redirect_valid;
        issue      = req_valid && bus.req_ready;
        push       = (state_q == StWait) && bus.resp_valid && !bus.redirect_valid;
        inst_valid = rst && (count_q != '0);
        pop        = inst_valid && bus.inst_ready;
    end

    assign bus.req_valid  = req_valid;
    assign bus.req_addr   = pc_q;
    assign bus.fetch_pc   = pc_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = mem_inst[rd_ptr_q];
    assign bus.inst_pc    = mem_pc[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect_valid) begin
            // Flush: any response still owed by memory must be swallowed in StDrop.
            pc_q     <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            unique case (state_q)
                StIdle:  state_q <= StIdle;
                StWait:  state_q <= bus.resp_valid ? StIdle : StDrop;
                StDrop:  state_q <= bus.resp_valid ? StIdle : StDrop;
                default: state_q <= StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + XLEN'(4);
                        state_q  <= StWait;
                    end
                end
                StWait:  if (bus.resp_valid) state_q <= StIdle;
                StDrop:  if (bus.resp_valid) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (push) begin
                mem_inst[wr_ptr_q] <= bus.resp_data;
                mem_pc[wr_ptr_q]   <= req_pc_q;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060337_fetch_unit.md
Name: ysyx_23060337_fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the free-running PC register (next_pc = pc + 4) and fixed-latency IFU.
- Owns the PC and issues one outstanding request at a time to a valid/ready instruction-memory port.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO feeding the IDU through a valid/ready handshake.
- Adds redirect, meaning a branch/jump flush, with in-flight response dropping.

Parameters:
XLEN, 32, address/data width.
RESET_PC, 32'h80000000, PC value after reset.
DEPTH, 4, instruction FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-low reset (0 = reset).
redirect_valid  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
req_valid  output  1  memory request valid.
req_ready  input  1  memory accepts request.
req_addr  output  XLEN  request address; equals the pc register.
resp_valid  input  1  response data valid; at most one per accepted request, no earlier than the cycle after acceptance.
resp_data  input  XLEN  instruction word.
inst_valid  output  1  FIFO head valid (count != 0).
inst_ready  input  1  consumer accepts head.
inst  output  XLEN  FIFO head instruction.
inst_pc  output  XLEN  PC of FIFO head.
fetch_pc  output  XLEN  current pc register, for debug.

Behaviour:
- Reset (rst == 0 at the clock edge):
  - pc = RESET_PC; state = IDLE; FIFO count, read pointer and write pointer = 0.
  - While rst == 0, req_valid and inst_valid are 0.
  - Reset mid-transaction abandons any outstanding response. The memory side must not return it after reset.
- States:
  - IDLE: no outstanding request.
  - WAIT: request accepted, response pending; the request's PC is held in req_pc_q.
  - DROP: response pending but must be discarded.
- req_valid = rst && state == IDLE && count < DEPTH && !redirect_valid. This is combinational from redirect_valid.
- IDLE:
  - If req_valid && req_ready: req_pc_q <= pc; pc <= pc + 4 (mod 2^XLEN, wraps silently); go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - resp_valid without redirect: push {resp_data, req_pc_q} to the FIFO; go to IDLE.
  - A request may issue again the cycle after the response, so peak throughput is 1 instruction per 2 cycles plus memory latency.
- DROP:
  - resp_valid: discard the data; go to IDLE.
  - No response: stay in DROP.
- Redirect (redirect_valid == 1), highest priority after reset:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - FIFO flushed: count and both pointers = 0 next cycle.
  - IDLE stays IDLE, with no request that cycle.
  - WAIT with resp_valid in the same cycle: data discarded; go to IDLE.
  - WAIT without resp_valid: go to DROP.
  - DROP stays in DROP, or goes to IDLE if resp_valid that cycle.
  - Repeated redirects: the last one wins.
- FIFO:
  - Pop on inst_valid && inst_ready.
  - A pop in a redirect cycle counts as a completed handshake; the FIFO is still flushed.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by construction, because issue requires count < DEPTH and only one request is outstanding. The bench asserts it never occurs.
  - The head is registered storage, so inst and inst_pc are stable while inst_valid && !inst_ready.
- Ordering: instructions leave in issue order, and inst_pc is monotonic +4 between redirects.
- Latency: memory response at cycle t gives inst_valid at t+1 if the FIFO was empty.

Test Plan:
- Reset release, req_ready = 1, 1-cycle memory latency, inst_ready = 1:
  - req_addr sequence is 0x80000000, 0x80000004, 0x80000008…
  - inst_pc matches with a 2-cycle lag.
  - No gaps beyond 1 instruction per 2 cycles.
- inst_ready = 0, DEPTH = 4:
  - Exactly 4 requests issue, then req_valid = 0.
  - inst/inst_pc stay stable at 0x80000000.
  - Raising inst_ready drains 4 entries in order, then fetch resumes at 0x80000010.
- Redirect to 0x80001002 while in WAIT, response arriving 3 cycles later:
  - Response is dropped and the FIFO is emptied.
  - Next req_addr = 0x80001000 after the drop.
  - No instruction with the old PC appears after the redirect.
- Redirect coincident with resp_valid in WAIT:
  - Data is not pushed; state goes to IDLE.
  - Next request is at the redirect target in the following cycle.
- Assert rst = 0 for one cycle mid-WAIT with 2 FIFO entries:
  - Next cycle inst_valid = 0 and fetch_pc = 0x80000000.
  - The first request after reset is at 0x80000000.
- Wrap: redirect to 0xFFFFFFFC:
  - Requests go 0xFFFFFFFC, then 0x00000000.
  - inst_pc values match.
